adc_event_capture: RTL and testbench
====================================

# adc_event_capture

Trigger-driven event capture stage directly downstream of the 16-channel ADS52J90 deserializer. It continuously records the 384-bit per-`adc_clk` ADC word into a circular pre-trigger buffer. On an accepted trigger it freezes a frame of `PRE` + `POST` words and streams that frame out one channel lane per beat over a valid/ready interface to the readout path.

## Interface
Parameters:
- `PRE`, 8: pre-trigger words in a frame (≥1).
- `POST`, 24: post-trigger words, including the trigger word (≥1).
- `DEPTH`, 64: ring-buffer depth in words. Must be a power of two and ≥ `PRE`+`POST`+1.

Ports:
- `adc_clk`  in  1: the only clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `adc_data_in`  in  384: one ADC word per cycle. Lane i = bits [24i+23:24i] = {newer sample[11:0], older sample[11:0]} of channel i.
- `trig`  in  1: trigger request, sampled every cycle.
- `m_data`  out  24: one lane of a frame word.
- `m_chan`  out  4: channel index of `m_data`.
- `m_first`  out  1: first beat of frame (word 0, channel 0).
- `m_last`  out  1: last beat of frame (word `PRE`+`POST`-1, channel 15).
- `m_valid`  out  1: output beat valid.
- `m_ready`  in  1: downstream accepts beat.
- `busy`  out  1: high in CAPTURE or READ.
- `armed`  out  1: IDLE and pre-trigger history complete.
- `trig_dropped`  out  16: count of rejected triggers, saturating at 0xFFFF.

## Operation
- N = `PRE`+`POST` words per frame; 16·N beats per frame. Order is word-major, channel 0..15 within each word. Lanes are passed unmodified.
- Write pointer `wp` (log2 `DEPTH` bits) increments and writes `adc_data_in` every cycle in IDLE and CAPTURE. It wraps modulo `DEPTH`. No writes occur in READ.
- Fill counter counts words written since reset or since leaving READ, saturating at `PRE`. `armed` = IDLE && fill == `PRE`.
- States:
  - IDLE: if `trig` && armed → CAPTURE. Set `start` = `wp` − `PRE` (mod `DEPTH`), post counter = 1. The word written in that same cycle is frame word `PRE`.
  - CAPTURE: write one word per cycle. After the `POST`-th post-trigger word is written → READ.
  - READ: read address = `start` + word index (mod `DEPTH`). After the `m_last` beat is accepted → IDLE with fill = 0.
- Frame word k = the `adc_data_in` presented `PRE`−k cycles before the trigger cycle (k < `PRE`), or k−`PRE` cycles after it (k ≥ `PRE`).
- `trig` in CAPTURE or READ, or in IDLE with armed = 0, increments `trig_dropped` (saturating) and is otherwise ignored.
- A `trig` in the same cycle as the `m_last` acceptance is dropped.

## Timing
- Every output resets to 0: `m_data`, `m_chan`, `m_first`, `m_last`, `m_valid`, `busy`, `armed`, `trig_dropped`. The FSM resets to IDLE, and `wp`, fill, `start`, and the word/channel indices reset to 0.
- `busy` rises in the cycle after the accepted trigger. It falls in the cycle after the `m_last` acceptance.
- RAM read latency is 1 cycle. The first `m_valid` asserts exactly 2 cycles after entering READ.
- Handshake: a beat transfers when `m_valid` && `m_ready`. While `m_valid` is high and `m_ready` is low, `m_data`, `m_chan`, `m_first`, and `m_last` are held stable.
- With `m_ready` held high, throughput is 1 beat per cycle with no bubbles; the pipeline must prefetch or skid.
- `armed` first rises `PRE` cycles after the reset release, and again `PRE` cycles after READ ends.
- Reset asserted mid-CAPTURE or mid-READ aborts the frame. `m_valid` is 0 in the next cycle, and partial frames are never resumed.

## Structure
- Shared package `adc_pkg`:
  - `ADC_CH`=16, `ADC_BITS`=12, `LANE_W`=24, `WORD_W`=384.
  - State enum `cap_state_t` {IDLE, CAPTURE, READ}.
- Sub-module `sdp_ram`: simple dual-port RAM, `WORD_W` × `DEPTH`. It has one write port and one read port, with a registered 1-cycle-latency read. It infers BRAM.
- All remaining logic lives in `adc_event_capture`: FSM, pointers, counters, lane mux, and output skid register.

## Test plan
- Ramp: lane i of word w = {w[11:0], w[11:0]} ^ (i<<20). Release reset, assert `trig` once at cycle 20, `m_ready`=1. Expect 512 beats ordered word 12..43, channel 0..15. Expect `m_first` only on beat 0, `m_last` only on beat 511, and no gaps.
- Not armed: `trig` at cycle 3 after reset (fill < 8) → no frame, `trig_dropped`=1, `busy` stays 0.
- Back-pressure: toggle `m_ready` pseudo-randomly (50%) during readout → identical 512-beat frame to the ramp test. Data must be stable during every stall.
- Busy triggers: assert `trig` 5 times during CAPTURE/READ and once in the `m_last` accept cycle → `trig_dropped`=6. The next `trig`, issued ≥8 cycles after IDLE, yields a correct frame.
- Wrap-around: run 1000 cycles, then trigger so that `start` > `wp` (mod 64) → frame contents match the ramp reference across the wrap.
- Reset at READ beat 100 → the cycle after, all outputs are 0 and `armed`=0. A trigger 8 cycles after release produces a full correct frame.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants and state type for the ADC event-capture path.
package adc_pkg;
    localparam int ADC_CH   = 16;
    localparam int ADC_BITS = 12;
    localparam int LANE_W   = 2 * ADC_BITS;
    localparam int WORD_W   = ADC_CH * LANE_W;
    localparam int CH_W     = $clog2(ADC_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(ADC_CH - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, READ} cap_state_t;
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module sdp_ram #(
    parameter int W     = 384,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/adc_event_capture.sv
// Trigger-driven capture of ADC words into a ring buffer, then frame readout
// one channel lane per beat over valid/ready.
module adc_event_capture
    import adc_pkg::*;
#(
    parameter int PRE   = 8,
    parameter int POST  = 24,
    parameter int DEPTH = 64
) (
    input  logic              adc_clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] adc_data_in,
    input  logic              trig,
    output logic [LANE_W-1:0] m_data,
    output logic [CH_W-1:0]   m_chan,
    output logic              m_first,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              armed,
    output logic [15:0]       trig_dropped
);
    localparam int N  = PRE + POST;
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(PRE + 1);
    localparam int PW = $clog2(POST + 1);
    localparam int IW = $clog2(N + 1);
    localparam logic [FW-1:0] PRE_F  = FW'(PRE);
    localparam logic [AW-1:0] PRE_A  = AW'(PRE);
    localparam logic [PW-1:0] POST_L = PW'(POST - 1);
    localparam logic [IW-1:0] N_I    = IW'(N);
    localparam logic [IW-1:0] LAST_I = IW'(N - 1);

    cap_state_t        state_q;
    logic [AW-1:0]     wp_q, start_q;
    logic [FW-1:0]     fill_q;
    logic [PW-1:0]     post_q;
    logic [IW-1:0]     fetch_q, rword_q;
    logic [CH_W-1:0]   chan_q;
    logic              rvalid_q;

    logic              we, re, trig_ok, load, consume, last_acc;
    logic [AW-1:0]     raddr;
    logic [WORD_W-1:0] rdata;
    logic [LANE_W-1:0] lane;

    assign we       = (state_q == IDLE) || (state_q == CAPTURE);
    assign trig_ok  = (state_q == IDLE) && armed && trig;
    // The RAM output register doubles as the word buffer; the output
    // register acts as the skid stage, so a word is refetched in the same
    // cycle its last lane is consumed.
    assign load     = rvalid_q && (!m_valid || m_ready);
    assign consume  = load && (chan_q == LAST_CH);
    assign re       = (state_q == READ) && (fetch_q != N_I) && (!rvalid_q || consume);
    assign last_acc = m_valid && m_ready && m_last;
    assign raddr    = start_q + AW'(fetch_q);
    assign lane     = rdata[int'(chan_q) * LANE_W +: LANE_W];

    sdp_ram #(.W(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (adc_clk),
        .we    (we),
        .waddr (wp_q),
        .wdata (adc_data_in),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wp_q         <= '0;
            start_q      <= '0;
            fill_q       <= '0;
            post_q       <= '0;
            fetch_q      <= '0;
            rword_q      <= '0;
            chan_q       <= '0;
            rvalid_q     <= 1'b0;
            m_data       <= '0;
            m_chan       <= '0;
            m_first      <= 1'b0;
            m_last       <= 1'b0;
            m_valid      <= 1'b0;
            busy         <= 1'b0;
            armed        <= 1'b0;
            trig_dropped <= '0;
        end else begin
            if (we) wp_q <= wp_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (fill_q != PRE_F) fill_q <= fill_q + 1'b1;
                    if (trig_ok) begin
                        start_q <= wp_q - PRE_A;
                        post_q  <= PW'(1);
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    post_q <= post_q + 1'b1;
                    if (post_q >= POST_L) state_q <= READ;
                end
                READ: begin
                    if (re) begin
                        fetch_q <= fetch_q + 1'b1;
                        rword_q <= fetch_q;
                    end
                    if (load) chan_q <= chan_q + 1'b1;
                    if (re) rvalid_q <= 1'b1;
                    else if (consume) rvalid_q <= 1'b0;
                    if (last_acc) begin
                        state_q  <= IDLE;
                        fill_q   <= '0;
                        fetch_q  <= '0;
                        chan_q   <= '0;
                        rvalid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load) begin
                m_data  <= lane;
                m_chan  <= chan_q;
                m_first <= (rword_q == '0) && (chan_q == '0);
                m_last  <= (rword_q == LAST_I) && (chan_q == LAST_CH);
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            busy  <= (state_q == IDLE) ? trig_ok : !last_acc;
            // Mirrors the next-cycle fill count so armed is a clean register.
            armed <= (state_q == IDLE) && !trig_ok && (fill_q >= PRE_F - 1'b1);

            if (trig && !trig_ok && trig_dropped != 16'hFFFF)
                trig_dropped <= trig_dropped + 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_event_capture.sv
// Directed scenarios with randomized ready/data, checked against a frame-level
// reference model built from recorded input words.
module tb_adc_event_capture;
    import adc_pkg::*;

    localparam int PRE = 8, POST = 24, N = PRE + POST, BEATS = N * ADC_CH;

    logic              adc_clk = 1'b0, rst_n = 1'b0, trig = 1'b0, m_ready = 1'b0;
    logic [WORD_W-1:0] adc_data_in = '0;
    logic [LANE_W-1:0] m_data;
    logic [CH_W-1:0]   m_chan;
    logic              m_first, m_last, m_valid, busy, armed;
    logic [15:0]       trig_dropped;

    always #5 adc_clk = ~adc_clk;

    adc_event_capture #(.PRE(PRE), .POST(POST), .DEPTH(64)) dut (
        .adc_clk(adc_clk), .rst_n(rst_n), .adc_data_in(adc_data_in), .trig(trig),
        .m_data(m_data), .m_chan(m_chan), .m_first(m_first), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .armed(armed),
        .trig_dropped(trig_dropped)
    );

    typedef struct packed {
        logic [LANE_W-1:0] data;
        logic [CH_W-1:0]   chan;
        logic              first;
        logic              last;
    } beat_t;

    beat_t             expq[$];
    logic [WORD_W-1:0] hist[$];
    int    checks = 0, errors = 0;
    int    ncyc = 0, wcnt = 0, m_drop = 0, post_left = 0, frame_k = 0;
    int    nbeats = 0, first_v = -1, last_v = -1, trig_cyc = -1, rdy_pct = 100;
    bit    m_busy = 0, rand_data = 0, prev_stall = 0;
    beat_t prev_out;
    logic [LANE_W-1:0] first_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    function automatic logic [WORD_W-1:0] ramp(input int w);
        logic [WORD_W-1:0] r;
        logic [11:0] s;
        s = w[11:0];
        for (int i = 0; i < ADC_CH; i++) r[LANE_W*i +: LANE_W] = {s, s} ^ (24'(i) << 20);
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] rnd_word();
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_word(input logic [WORD_W-1:0] w, input int k);
        for (int c = 0; c < ADC_CH; c++)
            expq.push_back('{w[LANE_W*c +: LANE_W], CH_W'(c), (k == 0 && c == 0),
                             (k == N - 1 && c == ADC_CH - 1)});
    endtask

    task automatic step(input bit t, input bit rdy);
        beat_t cur, e;
        logic [WORD_W-1:0] w;
        bit was_busy;
        cur = '{m_data, m_chan, m_first, m_last};
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_hold", 32'(cur), 32'(prev_out));
        end
        w = rand_data ? rnd_word() : ramp(wcnt);
        adc_data_in = w; trig = t; m_ready = rdy;
        was_busy = m_busy;
        if (m_valid && first_v < 0) first_v = ncyc;
        if (m_valid && rdy) begin
            nbeats++;
            chk("beat_expected", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("beat", 32'(cur), 32'(e));
                if (e.first) first_data = cur.data;
                if (e.last) begin m_busy = 0; hist.delete(); last_v = ncyc; end
            end
        end
        if (!was_busy) begin
            if (t && hist.size() >= PRE) begin
                for (int k = 0; k < PRE; k++) push_word(hist[hist.size() - PRE + k], k);
                push_word(w, PRE);
                frame_k = PRE + 1; post_left = POST - 1; m_busy = 1; trig_cyc = ncyc;
            end else if (t) m_drop++;
            hist.push_back(w);
            if (hist.size() > PRE) void'(hist.pop_front());
        end else begin
            if (t) m_drop++;
            if (post_left > 0) begin push_word(w, frame_k); frame_k++; post_left--; end
        end
        prev_stall = m_valid && !rdy;
        prev_out = cur;
        @(posedge adc_clk); #1;
        ncyc++; wcnt++;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("armed", 32'(armed), 32'(!m_busy && hist.size() >= PRE));
        chk("trig_dropped", 32'(trig_dropped), 32'(m_drop));
        if (!m_busy) chk("valid_when_idle", 32'(m_valid), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; trig = 1'b0; m_ready = 1'b0;
        @(posedge adc_clk); #1;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_outs", {m_data, m_chan, m_first, m_last, busy, armed}, 0);
        chk("rst_drops", 32'(trig_dropped), 0);
        expq.delete(); hist.delete();
        m_busy = 0; m_drop = 0; post_left = 0; prev_stall = 0; wcnt = 0; nbeats = 0;
        @(posedge adc_clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1);
    endtask

    function automatic bit rdy_bit();
        return (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
    endfunction

    task automatic run_frame(input int tmode, input int pct);
        bit r, t;
        nbeats = 0; first_v = -1; last_v = -1; rdy_pct = pct;
        for (int i = 0; i < 4000 && (m_busy || expq.size() != 0); i++) begin
            r = rdy_bit();
            t = (tmode == 1) && ((i == 2 || i == 9 || i == 40 || i == 150 || i == 400) ||
                                 (m_valid && m_last && r));
            step(t, r);
        end
        chk("frame_done", 32'(m_busy), 0);
        chk("frame_beats", 32'(nbeats), BEATS);
    endtask

    initial begin
        logic [WORD_W-1:0] w12;

        // trigger before the pre-trigger history is complete
        do_reset();
        idle(3);
        step(1'b1, 1'b1);
        idle(10);
        chk("notarmed_drops", 32'(trig_dropped), 1);
        chk("notarmed_busy", 32'(busy), 0);

        // ramp frame with continuous ready
        do_reset();
        idle(20);
        step(1'b1, 1'b1);
        run_frame(0, 100);
        chk("first_valid_latency", 32'(first_v - trig_cyc), POST + 2);
        chk("no_gaps", 32'(last_v - first_v), BEATS - 1);
        w12 = ramp(12);
        chk("ramp_word12", 32'(first_data), 32'(w12[LANE_W-1:0]));

        // back-pressure
        do_reset();
        idle(20);
        step(1'b1, 1'b1);
        run_frame(0, 50);

        // triggers while busy, then a random-data frame
        do_reset();
        idle(10);
        step(1'b1, 1'b1);
        run_frame(1, 100);
        chk("busy_drops", 32'(trig_dropped), 6);
        idle(10);
        rand_data = 1;
        step(1'b1, 1'b1);
        run_frame(0, 70);
        rand_data = 0;

        // ring wrap: start pointer above write pointer
        do_reset();
        idle(1027);
        step(1'b1, 1'b1);
        run_frame(0, 100);

        // reset during readout, then a fresh frame
        do_reset();
        idle(20);
        step(1'b1, 1'b1);
        nbeats = 0;
        for (int i = 0; i < 2000 && nbeats < 100; i++) step(1'b0, 1'b1);
        chk("abort_point", 32'(nbeats), 100);
        do_reset();
        idle(8);
        step(1'b1, 1'b1);
        run_frame(0, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
